// File: rtl/speck_pkg.sv
// Shared SPECK128/128 constants and the round-scheduler state encoding.
package speck_pkg;

    localparam int WORD   = 64;
    localparam int ROUNDS = 32;
    localparam int IDX_W  = 5;
    localparam int ALPHA  = 8;
    localparam int BETA   = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        DONE
    } state_e;

endpackage

// File: rtl/speck_key_step.sv
// One combinational SPECK key-expansion step: (k, l, idx) -> (k', l').
module speck_key_step
    import speck_pkg::*;
#(
    parameter int W  = WORD,
    parameter int IW = IDX_W
) (
    input  logic [W-1:0]  k_i,
    input  logic [W-1:0]  l_i,
    input  logic [IW-1:0] idx_i,
    output logic [W-1:0]  k_o,
    output logic [W-1:0]  l_o
);

    logic [W-1:0] l_ror;
    logic [W-1:0] k_rol;
    logic [W-1:0] sum;

    assign l_ror = {l_i[ALPHA-1:0], l_i[W-1:ALPHA]};
    assign k_rol = {k_i[W-BETA-1:0], k_i[W-1:W-BETA]};
    assign sum   = k_i + l_ror;
    assign l_o   = sum ^ W'(idx_i);
    assign k_o   = k_rol ^ l_o;

endmodule

// File: rtl/speck_round_scheduler.sv
// Drives a shared SPECK round datapath through all rounds, expanding subkeys on the fly.
// Define SPECK_ROUND_TIMEOUT_EN to add the round_finished watchdog and the error output.
module speck_round_scheduler #(
    parameter int ROUNDS = speck_pkg::ROUNDS,
    parameter int WORD   = speck_pkg::WORD
`ifdef SPECK_ROUND_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2*WORD-1:0] key,
    input  logic [2*WORD-1:0] plaintext,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [2*WORD-1:0] ciphertext,
    output logic [4:0]        round_index,
    output logic              round_start,
    output logic [WORD-1:0]   round_subkey,
    output logic [2*WORD-1:0] round_block_in,
    input  logic [2*WORD-1:0] round_block_out,
    input  logic              round_finished
`ifdef SPECK_ROUND_TIMEOUT_EN
    ,
    output logic              error
`endif
);
    import speck_pkg::*;

    state_e              state_q, state_d;
    logic [2*WORD-1:0]   key_q, key_d;
    logic [2*WORD-1:0]   pt_q, pt_d;
    logic [2*WORD-1:0]   blk_q, blk_d;
    logic [2*WORD-1:0]   ct_q, ct_d;
    logic [WORD-1:0]     k_q, k_d;
    logic [WORD-1:0]     l_q, l_d;
    logic [WORD-1:0]     k_nxt, l_nxt;
    logic [IDX_W-1:0]    idx_q, idx_d;

`ifdef SPECK_ROUND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    speck_key_step #(
        .W  (WORD),
        .IW (IDX_W)
    ) u_key_step (
        .k_i   (k_q),
        .l_i   (l_q),
        .idx_i (idx_q),
        .k_o   (k_nxt),
        .l_o   (l_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            pt_q    <= '0;
            blk_q   <= '0;
            ct_q    <= '0;
            k_q     <= '0;
            l_q     <= '0;
            idx_q   <= '0;
`ifdef SPECK_ROUND_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            pt_q    <= pt_d;
            blk_q   <= blk_d;
            ct_q    <= ct_d;
            k_q     <= k_d;
            l_q     <= l_d;
            idx_q   <= idx_d;
`ifdef SPECK_ROUND_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        pt_d    = pt_q;
        blk_d   = blk_q;
        ct_d    = ct_q;
        k_d     = k_q;
        l_d     = l_q;
        idx_d   = idx_q;
`ifdef SPECK_ROUND_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key;
                    pt_d    = plaintext;
                    state_d = LOAD;
`ifdef SPECK_ROUND_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            LOAD: begin
                blk_d   = pt_q;
                k_d     = key_q[WORD-1:0];
                l_d     = key_q[2*WORD-1:WORD];
                idx_d   = '0;
                state_d = ISSUE;
            end
            // round_finished may still be high from the previous round here; never sample it.
            ISSUE: begin
                state_d = WAIT;
`ifdef SPECK_ROUND_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            WAIT: begin
                if (round_finished) begin
                    blk_d = round_block_out;
                    k_d   = k_nxt;
                    l_d   = l_nxt;
                    if (idx_q == IDX_W'(ROUNDS - 1)) begin
                        ct_d    = round_block_out;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
`ifdef SPECK_ROUND_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready          = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign round_start    = (state_q == ISSUE);
    assign round_index    = idx_q;
    assign round_subkey   = k_q;
    assign round_block_in = blk_q;
    assign ciphertext     = ct_q;
`ifdef SPECK_ROUND_TIMEOUT_EN
    assign error          = err_q;
`endif

endmodule
